// File: rtl/vdp_sched_pkg.sv
// Shared types and constants for the super-res VRAM access scheduler.
package vdp_sched_pkg;

    // Debug-visible owner of the current access window.
    typedef enum logic [2:0] {
        OWN_IDLE    = 3'd0,
        OWN_DISP    = 3'd1,
        OWN_CPU_RD  = 3'd2,
        OWN_CPU_WR  = 3'd3,
        OWN_REFRESH = 3'd4
    } owner_t;

    // Slot phases taken from cx[1:0]: window A = DL/DA, window B = AP/FS.
    localparam logic [1:0] PH_DL = 2'd0;
    localparam logic [1:0] PH_DA = 2'd1;
    localparam logic [1:0] PH_AP = 2'd2;
    localparam logic [1:0] PH_FS = 2'd3;

endpackage

// File: rtl/vdp_sched_refresh_timer.sv
// Slot counter that raises refresh_due once every REFRESH_INTERVAL slots.
module vdp_sched_refresh_timer #(
    parameter int unsigned REFRESH_INTERVAL = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic served,
    output logic refresh_due
);

    localparam int unsigned CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    logic [CW-1:0] slot_cnt;
    logic          wrap;

    assign wrap = (slot_cnt == CW'(REFRESH_INTERVAL - 1));

    // Count slots at phase-3 edges; a wrap while already due leaves the flag set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_cnt    <= '0;
            refresh_due <= 1'b0;
        end else begin
            if (tick) begin
                slot_cnt <= wrap ? '0 : slot_cnt + CW'(1);
            end
            if (tick && wrap) begin
                refresh_due <= 1'b1;
            end else if (served) begin
                refresh_due <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vdp_super_vram_scheduler.sv
// Per-slot VRAM window scheduler for super-resolution modes.
// Window A (phases 0-1): display fetch, else idle; with VRAM_SCHED_CPU_BOOST_EN
// defined an idle window A is handed to a pending CPU request instead.
// Window B (phases 2-3): refresh when due, else CPU, else idle.
module vdp_super_vram_scheduler
    import vdp_sched_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdp_super,
    input  logic [10:0] cx,
    input  logic        super_res_drawing,
    input  logic [16:0] super_res_vram_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [16:0] vram_addr,
    output logic        vram_we,
    output logic        vram_oe,
    output logic [7:0]  vram_wdata,
    input  logic [31:0] vram_rdata,
    output logic        vram_refresh,
    output logic [2:0]  owner
);

    owner_t     state;
    logic       sync_rst_n;
    logic [1:0] phase;
    logic       refresh_due;
    logic       refresh_served;
    logic       cpu_req_new;
    logic       cpu_busy;
    logic [1:0] cpu_lane;
    logic       unused_cx;

    assign sync_rst_n     = reset_n & vdp_super;
    assign phase          = cx[1:0];
    assign unused_cx      = ^cx[10:2];
    assign refresh_served = (phase == PH_AP) && refresh_due;
    // The request is still high during its own ack cycle; it is not a new one yet.
    assign cpu_req_new    = cpu_req && !cpu_ack;
    assign owner          = state;

    vdp_sched_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk        (clk),
        .reset_n    (sync_rst_n),
        .tick       (phase == PH_FS),
        .served     (refresh_served),
        .refresh_due(refresh_due)
    );

    // Owner FSM: grants at window-start edges, completes CPU accesses mid-window.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state        <= OWN_IDLE;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= 8'h00;
            vram_addr    <= 17'h00000;
            vram_we      <= 1'b0;
            vram_oe      <= 1'b0;
            vram_wdata   <= 8'h00;
            vram_refresh <= 1'b0;
            cpu_busy     <= 1'b0;
            cpu_lane     <= 2'd0;
        end else begin
            cpu_ack      <= 1'b0;
            vram_refresh <= 1'b0;
            case (phase)
                PH_DL: begin
                    cpu_busy <= 1'b0;
                    if (super_res_drawing) begin
                        state     <= OWN_DISP;
                        vram_addr <= super_res_vram_addr;
                        vram_we   <= 1'b0;
                        vram_oe   <= 1'b1;
`ifdef VRAM_SCHED_CPU_BOOST_EN
                    end else if (cpu_req_new) begin
                        state      <= cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
                        vram_addr  <= cpu_addr;
                        vram_we    <= cpu_we;
                        vram_oe    <= !cpu_we;
                        vram_wdata <= cpu_wdata;
                        cpu_lane   <= cpu_addr[1:0];
                        cpu_busy   <= 1'b1;
`endif
                    end else begin
                        state     <= OWN_IDLE;
                        vram_addr <= 17'h00000;
                        vram_we   <= 1'b0;
                        vram_oe   <= 1'b0;
                    end
                end
                PH_AP: begin
                    cpu_busy <= 1'b0;
                    if (refresh_due) begin
                        state        <= OWN_REFRESH;
                        vram_refresh <= 1'b1;
                        vram_addr    <= 17'h00000;
                        vram_we      <= 1'b0;
                        vram_oe      <= 1'b0;
                    end else if (cpu_req_new) begin
                        state      <= cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
                        vram_addr  <= cpu_addr;
                        vram_we    <= cpu_we;
                        vram_oe    <= !cpu_we;
                        vram_wdata <= cpu_wdata;
                        cpu_lane   <= cpu_addr[1:0];
                        cpu_busy   <= 1'b1;
                    end else begin
                        state     <= OWN_IDLE;
                        vram_addr <= 17'h00000;
                        vram_we   <= 1'b0;
                        vram_oe   <= 1'b0;
                    end
                end
                default: begin
                    // Second edge of a window: finish a CPU access exactly once.
                    if (cpu_busy) begin
                        if (state == OWN_CPU_RD) begin
                            cpu_rdata <= vram_rdata[{cpu_lane, 3'b000} +: 8];
                        end
                        cpu_ack  <= 1'b1;
                        cpu_busy <= 1'b0;
                        vram_we  <= 1'b0;
                        vram_oe  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_super_vram_scheduler.sv
// Directed bench for vdp_super_vram_scheduler (default build, REFRESH_INTERVAL = 8).
module tb_vdp_super_vram_scheduler;
    import vdp_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vdp_super;
    logic [10:0] cx;
    logic        super_res_drawing;
    logic [16:0] super_res_vram_addr;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [16:0] vram_addr;
    logic        vram_we;
    logic        vram_oe;
    logic [7:0]  vram_wdata;
    logic [31:0] vram_rdata;
    logic        vram_refresh;
    logic [2:0]  owner;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          acks;
    int          refs;
    int          b2b;
    int          ref_cx;
    logic        prev_ack;
    logic [10:0] scx;

    vdp_super_vram_scheduler #(.REFRESH_INTERVAL(8)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .vdp_super          (vdp_super),
        .cx                 (cx),
        .super_res_drawing  (super_res_drawing),
        .super_res_vram_addr(super_res_vram_addr),
        .cpu_req            (cpu_req),
        .cpu_we             (cpu_we),
        .cpu_addr           (cpu_addr),
        .cpu_wdata          (cpu_wdata),
        .cpu_ack            (cpu_ack),
        .cpu_rdata          (cpu_rdata),
        .vram_addr          (vram_addr),
        .vram_we            (vram_we),
        .vram_oe            (vram_oe),
        .vram_wdata         (vram_wdata),
        .vram_rdata         (vram_rdata),
        .vram_refresh       (vram_refresh),
        .owner              (owner)
    );

    always #5 clk = ~clk;

    // One pixel clock: the edge samples the current cx, then cx advances.
    task automatic step();
        @(posedge clk);
        #1;
        cx = cx + 11'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; vdp_super = 1'b1; cx = 11'd0;
        super_res_drawing = 1'b0; super_res_vram_addr = 17'h00000;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h12345; cpu_wdata = 8'h5A;
        vram_rdata = 32'h0;

        // Reset held with a pending CPU request.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_ack", 32'(cpu_ack), 32'd0);
            chk("rst_we", 32'(vram_we), 32'd0);
        end
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_oe", 32'(vram_oe), 32'd0);
        chk("rst_refresh", 32'(vram_refresh), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_owner", 32'(owner), 32'(OWN_IDLE));

        reset_n = 1'b1;                                   // cx = 4
        step();                                           // edge 4 (phase 0)
        chk("post_rst_ph0_owner", 32'(owner), 32'(OWN_IDLE));
        chk("post_rst_ph0_ack", 32'(cpu_ack), 32'd0);
        step();                                           // edge 5
        step();                                           // edge 6 (window B grant)
        chk("wr1_owner", 32'(owner), 32'(OWN_CPU_WR));
        chk("wr1_addr", 32'(vram_addr), 32'h12345);
        chk("wr1_we", 32'(vram_we), 32'd1);
        chk("wr1_oe", 32'(vram_oe), 32'd0);
        chk("wr1_wdata", 32'(vram_wdata), 32'h5A);
        chk("wr1_ack_early", 32'(cpu_ack), 32'd0);
        step();                                           // edge 7
        chk("wr1_ack", 32'(cpu_ack), 32'd1);
        chk("wr1_we_drop", 32'(vram_we), 32'd0);
        step();                                           // edge 8, req still high
        chk("wr1_ack_single", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        step(); step(); step();                           // edges 9..11

        // Display fetch in window A.
        super_res_drawing = 1'b1; super_res_vram_addr = 17'h00100;
        step();                                           // edge 12
        chk("disp_owner", 32'(owner), 32'(OWN_DISP));
        chk("disp_addr", 32'(vram_addr), 32'h00100);
        chk("disp_oe", 32'(vram_oe), 32'd1);
        super_res_drawing = 1'b0; super_res_vram_addr = 17'h1FFFF;
        step();                                           // edge 13
        chk("disp_hold_addr", 32'(vram_addr), 32'h00100);
        chk("disp_hold_oe", 32'(vram_oe), 32'd1);
        chk("disp_hold_owner", 32'(owner), 32'(OWN_DISP));
        step();                                           // edge 14
        chk("disp_end_owner", 32'(owner), 32'(OWN_IDLE));
        chk("disp_end_oe", 32'(vram_oe), 32'd0);
        step();                                           // edge 15

        // CPU byte read from lane 3.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00007; vram_rdata = 32'hAABBCCDD;
        step(); step();                                   // edges 16, 17
        step();                                           // edge 18
        chk("rd_owner", 32'(owner), 32'(OWN_CPU_RD));
        chk("rd_addr", 32'(vram_addr), 32'h00007);
        chk("rd_oe", 32'(vram_oe), 32'd1);
        chk("rd_we", 32'(vram_we), 32'd0);
        step();                                           // edge 19
        chk("rd_ack", 32'(cpu_ack), 32'd1);
        chk("rd_rdata", 32'(cpu_rdata), 32'hAA);
        chk("rd_oe_drop", 32'(vram_oe), 32'd0);
        step();                                           // edge 20
        chk("rd_ack_single", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        step(); step(); step();                           // edges 21..23, cx = 24

        // Continuous writes over 8 slots; refresh takes one window B.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h0ABCD; cpu_wdata = 8'h3C;
        acks = 0; refs = 0; b2b = 0; ref_cx = -1; prev_ack = cpu_ack;
        for (int i = 0; i < 32; i++) begin
            scx = cx;
            step();
            if (cpu_ack) acks++;
            if (cpu_ack && prev_ack) b2b++;
            prev_ack = cpu_ack;
            if (vram_refresh) begin
                refs++;
                ref_cx = int'(scx);
                chk("ref_owner", 32'(owner), 32'(OWN_REFRESH));
                chk("ref_no_we", 32'(vram_we), 32'd0);
            end
            if (scx == 11'd42) begin
                chk("post_ref_owner", 32'(owner), 32'(OWN_CPU_WR));
                chk("post_ref_wdata", 32'(vram_wdata), 32'h3C);
            end
        end
        chk("burst_acks", 32'(acks), 32'd7);
        chk("burst_refs", 32'(refs), 32'd1);
        chk("burst_ref_cx", 32'(ref_cx), 32'd38);
        chk("burst_no_b2b", 32'(b2b), 32'd0);

        // Two queued writes: second ack one slot after the first.
        cpu_addr = 17'h00010;                             // cx = 56
        step();                                           // edge 56
        chk("q_ack_clear", 32'(cpu_ack), 32'd0);
        step();                                           // edge 57
        step();                                           // edge 58
        chk("q1_addr", 32'(vram_addr), 32'h00010);
        step();                                           // edge 59
        chk("q1_ack", 32'(cpu_ack), 32'd1);
        cpu_addr = 17'h00020;
        step();                                           // edge 60
        chk("q1_ack_single", 32'(cpu_ack), 32'd0);
        step(); step();                                   // edges 61, 62
        chk("q2_addr", 32'(vram_addr), 32'h00020);
        chk("q2_ack_early", 32'(cpu_ack), 32'd0);
        step();                                           // edge 63
        chk("q2_ack", 32'(cpu_ack), 32'd1);

        // vdp_super dropped mid write.
        cpu_addr = 17'h00030; cpu_wdata = 8'hC3;
        step(); step(); step();                           // edges 64..66
        chk("sup_we", 32'(vram_we), 32'd1);
        chk("sup_addr", 32'(vram_addr), 32'h00030);
        vdp_super = 1'b0;
        step();                                           // edge 67
        chk("sup_off_we", 32'(vram_we), 32'd0);
        chk("sup_off_ack", 32'(cpu_ack), 32'd0);
        chk("sup_off_owner", 32'(owner), 32'(OWN_IDLE));
        chk("sup_off_addr", 32'(vram_addr), 32'd0);
        super_res_drawing = 1'b1;
        step();                                           // edge 68
        chk("sup_off_disp_oe", 32'(vram_oe), 32'd0);
        chk("sup_off_disp_owner", 32'(owner), 32'(OWN_IDLE));
        step();                                           // edge 69
        chk("sup_off_ack2", 32'(cpu_ack), 32'd0);
        vdp_super = 1'b1; super_res_drawing = 1'b0;
        step();                                           // edge 70
        chk("sup_reserve_owner", 32'(owner), 32'(OWN_CPU_WR));
        chk("sup_reserve_we", 32'(vram_we), 32'd1);
        step();                                           // edge 71
        chk("sup_reserve_ack", 32'(cpu_ack), 32'd1);

        // cx discontinuity truncates window B; access abandoned, then re-served.
        step(); step(); step();                           // edges 72..74
        chk("trunc_we", 32'(vram_we), 32'd1);
        cx = 11'd76;
        step();                                           // edge 76
        chk("trunc_abandon_we", 32'(vram_we), 32'd0);
        chk("trunc_abandon_owner", 32'(owner), 32'(OWN_IDLE));
        chk("trunc_abandon_ack", 32'(cpu_ack), 32'd0);
        step();                                           // edge 77
        chk("trunc_no_ack", 32'(cpu_ack), 32'd0);
        step();                                           // edge 78
        chk("trunc_regrant", 32'(owner), 32'(OWN_CPU_WR));
        step();                                           // edge 79
        chk("trunc_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        step();                                           // edge 80
        chk("final_ack_clear", 32'(cpu_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
